// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/move ops plus an iterative shift-add MULT/MULTU.
// Define EX_EARLY_TERM_EN to let the multiplier stop once the remaining multiplier bits are zero.
module ex_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       aluop_i,
    input  logic [2:0]       alusel_i,
    input  logic [WIDTH-1:0] reg1_i,
    input  logic [WIDTH-1:0] reg2_i,
    input  logic [4:0]       wd_i,
    input  logic             wreg_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             flush_i,
    output logic [4:0]       wd_o,
    output logic             wreg_o,
    output logic [WIDTH-1:0] wdata_o,
    output logic             whilo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             stallreq_o
);

    localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
    localparam logic [7:0] EXE_MOVZ_OP  = 8'b00001010;
    localparam logic [7:0] EXE_MOVN_OP  = 8'b00001011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;

    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [2*WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0]   mplier_reg, mplier_next;
    logic               sign_reg, sign_next;

    logic               is_mult, is_mul_op;
    logic [WIDTH-1:0]   mag1, mag2;
    logic               mul_stall, mul_done, last_step;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH-1:0]   logic_res, shift_res, move_res;
    logic [CNT_W-1:0]   sh_amt;

    assign is_mult   = (aluop_i == EXE_MULT_OP);
    assign is_mul_op = is_mult || (aluop_i == EXE_MULTU_OP);
    // Signed multiply runs on magnitudes; the most negative value maps onto itself as unsigned.
    assign mag1      = (is_mult && reg1_i[WIDTH-1]) ? (~reg1_i + 1'b1) : reg1_i;
    assign mag2      = (is_mult && reg2_i[WIDTH-1]) ? (~reg2_i + 1'b1) : reg2_i;
    assign product   = sign_reg ? (~acc_reg + 1'b1) : acc_reg;
    assign sh_amt    = reg1_i[CNT_W-1:0];

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        sign_next   = sign_reg;
        mul_stall   = 1'b0;
        mul_done    = 1'b0;
        last_step   = (cnt_reg == '1);
`ifdef EX_EARLY_TERM_EN
        last_step   = last_step || ((mplier_reg >> 1) == '0);
`endif
        case (state_reg)
            S_IDLE: begin
                if (is_mul_op && !flush_i) begin
                    mcand_next  = {{WIDTH{1'b0}}, mag1};
                    mplier_next = mag2;
                    sign_next   = is_mult && (reg1_i[WIDTH-1] ^ reg2_i[WIDTH-1]);
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = S_MUL;
                    mul_stall   = 1'b1;
                end
            end
            S_MUL: begin
                mul_stall = 1'b1;
                if (mplier_reg[0]) begin
                    acc_next = acc_reg + mcand_reg;
                end
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + 1'b1;
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                mul_done   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (flush_i) begin
            state_next = S_IDLE;
            mul_stall  = 1'b0;
            mul_done   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            sign_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            sign_reg   <= sign_next;
        end
    end

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << sh_amt;
            EXE_SRL_OP: shift_res = reg2_i >> sh_amt;
            EXE_SRA_OP: shift_res = $signed(reg2_i) >>> sh_amt;
            default:    shift_res = '0;
        endcase
    end

    always_comb begin
        move_res = '0;
        case (aluop_i)
            EXE_MFHI_OP: move_res = hi_i;
            EXE_MFLO_OP: move_res = lo_i;
            EXE_MOVZ_OP: move_res = reg1_i;
            EXE_MOVN_OP: move_res = reg1_i;
            default:     move_res = '0;
        endcase
    end

    always_comb begin
        wd_o       = wd_i;
        wdata_o    = '0;
        wreg_o     = wreg_i;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = mul_stall;
        case (alusel_i)
            EXE_RES_LOGIC: wdata_o = logic_res;
            EXE_RES_SHIFT: wdata_o = shift_res;
            EXE_RES_MOVE:  wdata_o = move_res;
            default:       wdata_o = '0;
        endcase
        if (aluop_i == EXE_MOVZ_OP) begin
            wreg_o = wreg_i && (reg2_i == '0);
        end else if (aluop_i == EXE_MOVN_OP) begin
            wreg_o = wreg_i && (reg2_i != '0);
        end
        if (aluop_i == EXE_MTHI_OP) begin
            whilo_o = 1'b1;
            hi_o    = reg1_i;
            lo_o    = lo_i;
        end else if (aluop_i == EXE_MTLO_OP) begin
            whilo_o = 1'b1;
            hi_o    = hi_i;
            lo_o    = reg1_i;
        end
        // Multiplier results overwrite whatever the still-held MULT inputs decode to.
        if (mul_done) begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = product;
            wreg_o       = 1'b0;
            wdata_o      = '0;
        end else if (state_reg == S_MUL || mul_stall) begin
            whilo_o = 1'b0;
            hi_o    = '0;
            lo_o    = '0;
        end
        if (flush_i) begin
            wreg_o  = 1'b0;
            whilo_o = 1'b0;
        end
        if (!rst) begin
            wd_o       = '0;
            wdata_o    = '0;
            wreg_o     = 1'b0;
            whilo_o    = 1'b0;
            hi_o       = '0;
            lo_o       = '0;
            stallreq_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected results queued at drive time, popped when the DUT answers.
// Honours EX_EARLY_TERM_EN for multiplier latency expectations.
module tb_ex_stage;

    localparam logic [7:0] OP_NOP   = 8'b00000000;
    localparam logic [7:0] OP_AND   = 8'b00100100;
    localparam logic [7:0] OP_OR    = 8'b00100101;
    localparam logic [7:0] OP_XOR   = 8'b00100110;
    localparam logic [7:0] OP_NOR   = 8'b00100111;
    localparam logic [7:0] OP_SLL   = 8'b01111100;
    localparam logic [7:0] OP_SRL   = 8'b00000010;
    localparam logic [7:0] OP_SRA   = 8'b00000011;
    localparam logic [7:0] OP_MOVZ  = 8'b00001010;
    localparam logic [7:0] OP_MOVN  = 8'b00001011;
    localparam logic [7:0] OP_MFHI  = 8'b00010000;
    localparam logic [7:0] OP_MTHI  = 8'b00010001;
    localparam logic [7:0] OP_MFLO  = 8'b00010010;
    localparam logic [7:0] OP_MTLO  = 8'b00010011;
    localparam logic [7:0] OP_MULT  = 8'b00011000;
    localparam logic [7:0] OP_MULTU = 8'b00011001;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;

    localparam logic [31:0] HI_V = 32'hCAFE0001;
    localparam logic [31:0] LO_V = 32'h0BAD0002;
`ifdef EX_EARLY_TERM_EN
    localparam int FLUSH_AT = 2;
`else
    localparam int FLUSH_AT = 10;
`endif

    typedef struct {
        string       tag;
        logic [31:0] wdata;
        logic        wreg;
        logic [4:0]  wd;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
    } exp_t;

    logic        clk, rst, wreg, flush, wreg_o, whilo_o, stallreq_o;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2, hi, lo, wdata_o, hi_o, lo_o;
    logic [4:0]  wd, wd_o;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    ex_stage #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
        .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg),
        .hi_i(hi), .lo_i(lo), .flush_i(flush),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input logic w);
        aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = d; wreg = w;
    endtask

    function automatic exp_t mk(input logic [31:0] wdata, input logic wr, input logic [4:0] d,
                                input logic whl, input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.tag = ""; e.wdata = wdata; e.wreg = wr; e.wd = d;
        e.whilo = whl; e.hi = h; e.lo = l; e.stalls = 0;
        return e;
    endfunction

    function automatic exp_t model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] d, input logic w);
        exp_t e;
        e = mk(32'h0, w, d, 1'b0, 32'h0, 32'h0);
        case (op)
            OP_AND:  e.wdata = a & b;
            OP_OR:   e.wdata = a | b;
            OP_XOR:  e.wdata = a ^ b;
            OP_NOR:  e.wdata = ~(a | b);
            OP_SLL:  e.wdata = b << a[4:0];
            OP_SRL:  e.wdata = b >> a[4:0];
            OP_SRA:  e.wdata = $signed(b) >>> a[4:0];
            OP_MFHI: e.wdata = HI_V;
            OP_MFLO: e.wdata = LO_V;
            OP_MOVZ: begin e.wdata = a; e.wreg = w && (b == 0); end
            OP_MOVN: begin e.wdata = a; e.wreg = w && (b != 0); end
            OP_MTHI: begin e.whilo = 1'b1; e.hi = a; e.lo = LO_V; end
            OP_MTLO: begin e.whilo = 1'b1; e.hi = HI_V; e.lo = a; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic int exp_stalls(input logic sgn, input logic [31:0] b);
        int n;
        logic [31:0] m;
        m = (sgn && b[31]) ? (~b + 32'd1) : b;
        n = 32;
`ifdef EX_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`else
        if (m === 32'hx) n = 0;
`endif
        return 1 + n;
    endfunction

    task automatic run_single(input string tag, input logic [7:0] op, input logic [2:0] sel,
                              input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                              input logic w, input exp_t e);
        exp_t g;
        drive(op, sel, a, b, d, w);
        e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
        g = sb_q.pop_front();
        check_val({g.tag, ".wdata"}, wdata_o, g.wdata);
        check_val({g.tag, ".wreg"}, wreg_o, g.wreg);
        check_val({g.tag, ".wd"}, wd_o, g.wd);
        check_val({g.tag, ".whilo"}, whilo_o, g.whilo);
        check_val({g.tag, ".hi"}, hi_o, g.hi);
        check_val({g.tag, ".lo"}, lo_o, g.lo);
        check_val({g.tag, ".stall"}, stallreq_o, 0);
        $display("txn %s op=%h a=%h b=%h -> wdata=%h wreg=%b whilo=%b hi=%h lo=%h",
                 g.tag, op, a, b, wdata_o, wreg_o, whilo_o, hi_o, lo_o);
        @(posedge clk); #1;
    endtask

    task automatic run_mult(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e, g;
        logic [63:0] p;
        int stalls;
        bit done;
        if (sgn) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        else     p = {32'h0, a} * {32'h0, b};
        e = mk(32'h0, 1'b0, 5'd0, 1'b1, p[63:32], p[31:0]);
        e.tag = tag;
        e.stalls = exp_stalls(sgn, b);
        sb_q.push_back(e);
        drive(sgn ? OP_MULT : OP_MULTU, SEL_NOP, a, b, 5'd0, 1'b0);
        stalls = 0;
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (whilo_o) done = 1;
            else begin
                if (stallreq_o) stalls++;
                @(posedge clk); #1;
            end
        end
        g = sb_q.pop_front();
        check_val({g.tag, ".done"}, done, 1);
        check_val({g.tag, ".hi"}, hi_o, g.hi);
        check_val({g.tag, ".lo"}, lo_o, g.lo);
        check_val({g.tag, ".stalls"}, stalls, g.stalls);
        check_val({g.tag, ".stall_done"}, stallreq_o, 0);
        check_val({g.tag, ".wreg_done"}, wreg_o, 0);
        $display("txn %s a=%h b=%h -> hi=%h lo=%h stall_cycles=%0d", g.tag, a, b, hi_o, lo_o, stalls);
        @(posedge clk); #1;
    endtask

    logic [7:0]  tbl_op  [13] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                                  OP_MFHI, OP_MFLO, OP_MOVZ, OP_MOVN, OP_MTHI, OP_MTLO};
    logic [2:0]  tbl_sel [13] = '{SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_SHIFT, SEL_SHIFT,
                                  SEL_SHIFT, SEL_MOVE, SEL_MOVE, SEL_MOVE, SEL_MOVE, SEL_NOP, SEL_NOP};

    initial begin
        clk = 0; rst = 0; flush = 0; hi = HI_V; lo = LO_V;
        drive(OP_MTHI, SEL_NOP, 32'h11112222, 32'h0, 5'd5, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rst.wd", wd_o, 0);
        check_val("rst.wreg", wreg_o, 0);
        check_val("rst.wdata", wdata_o, 0);
        check_val("rst.whilo", whilo_o, 0);
        check_val("rst.hi", hi_o, 0);
        check_val("rst.lo", lo_o, 0);
        check_val("rst.stall", stallreq_o, 0);
        $display("txn reset outputs wd=%h wreg=%b whilo=%b stall=%b", wd_o, wreg_o, whilo_o, stallreq_o);
        @(posedge clk); #1;
        rst = 1;

        run_single("or", OP_OR, SEL_LOGIC, 32'h0000F0F0, 32'h00000F0F, 5'd5, 1'b1,
                   mk(32'h0000FFFF, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0));
        run_single("movz_hit", OP_MOVZ, SEL_MOVE, 32'h12345678, 32'h0, 5'd9, 1'b1,
                   mk(32'h12345678, 1'b1, 5'd9, 1'b0, 32'h0, 32'h0));
        run_single("movz_miss", OP_MOVZ, SEL_MOVE, 32'h12345678, 32'h1, 5'd9, 1'b1,
                   mk(32'h12345678, 1'b0, 5'd9, 1'b0, 32'h0, 32'h0));
        run_single("sra_31", OP_SRA, SEL_SHIFT, 32'd31, 32'h80000000, 5'd3, 1'b1,
                   mk(32'hFFFFFFFF, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0));
        run_single("mtlo", OP_MTLO, SEL_NOP, 32'hA5A5A5A5, 32'h0, 5'd0, 1'b0,
                   mk(32'h0, 1'b0, 5'd0, 1'b1, HI_V, 32'hA5A5A5A5));

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 13; i++) begin
                logic [31:0] a, b;
                a = $urandom;
                b = (r == 1 && i >= 9) ? 32'h0 : $urandom;
                run_single($sformatf("tbl%0d_%0d", r, i), tbl_op[i], tbl_sel[i], a, b,
                           5'(i + 1), 1'b1, model(tbl_op[i], a, b, 5'(i + 1), 1'b1));
            end
        end

        run_mult("mult_m2x3", 1'b1, 32'hFFFFFFFE, 32'd3);
        run_mult("multu_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_mult("multu_b2b", 1'b0, 32'd2, 32'd3);
        run_mult("mult_min", 1'b1, 32'h80000000, 32'h80000000);
        run_mult("multu_3x5", 1'b0, 32'd3, 32'd5);
        run_mult("multu_x0", 1'b0, 32'h12345678, 32'h0);
        for (int i = 0; i < 3; i++) begin
            run_mult($sformatf("mult_rnd%0d", i), 1'b1, $urandom, $urandom);
        end

        drive(OP_MULT, SEL_NOP, 32'd7, 32'd9, 5'd0, 1'b0);
        @(negedge clk);
        check_val("flush.start_stall", stallreq_o, 1);
        @(posedge clk); #1;
        for (int k = 1; k < FLUSH_AT; k++) begin
            @(negedge clk);
            check_val("flush.mul_whilo", whilo_o, 0);
            check_val("flush.mul_stall", stallreq_o, 1);
            @(posedge clk); #1;
        end
        flush = 1;
        @(negedge clk);
        check_val("flush.stall", stallreq_o, 0);
        check_val("flush.whilo", whilo_o, 0);
        check_val("flush.wreg", wreg_o, 0);
        @(posedge clk); #1;
        flush = 0;
        drive(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        check_val("flush.idle_stall", stallreq_o, 0);
        check_val("flush.idle_whilo", whilo_o, 0);
        $display("txn flush mid-mul stall=%b whilo=%b", stallreq_o, whilo_o);
        @(posedge clk); #1;
        run_mult("mult_after_flush", 1'b1, 32'd7, 32'd9);

        drive(OP_MULT, SEL_NOP, 32'h1234, 32'h5678, 5'd7, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check_val("rstmul.wd", wd_o, 0);
        check_val("rstmul.wreg", wreg_o, 0);
        check_val("rstmul.whilo", whilo_o, 0);
        check_val("rstmul.stall", stallreq_o, 0);
        check_val("rstmul.hilo", {hi_o, lo_o}, 0);
        @(posedge clk); #1;
        rst = 1;
        drive(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        check_val("rstmul.idle_stall", stallreq_o, 0);
        $display("txn reset mid-mul stall=%b", stallreq_o);
        @(posedge clk); #1;
        run_mult("mult_after_rst", 1'b0, 32'h1234, 32'h5678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. It consumes the registered decode outputs (aluop, alusel, operands, destination, write enable) and produces the GPR write-back and HI/LO write requests for the ex/mem register.
- Logic, shift and move ops complete in the same cycle.
- MULT/MULTU run on an iterative 32-step shift-add multiplier. While it runs, stallreq_o holds the upstream pipeline.

Parameters:
- WIDTH, 32, datapath and operand width. The product is 2*WIDTH.
- CNT_W, 5, iteration counter width. Must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- aluop_i  in  8  operation code (`EXE_*_OP encodings)
- alusel_i  in  3  result class (`EXE_RES_LOGIC/SHIFT/MOVE/NOP)
- reg1_i  in  WIDTH  operand 1 (rs); shift amount in [4:0] for shifts
- reg2_i  in  WIDTH  operand 2 (rt)
- wd_i  in  5  destination GPR address
- wreg_i  in  1  GPR write enable from decode
- hi_i  in  WIDTH  current HI value, already forwarded
- lo_i  in  WIDTH  current LO value, already forwarded
- flush_i  in  1  abort the in-flight instruction
- wd_o  out  5  destination GPR address
- wreg_o  out  1  GPR write enable
- wdata_o  out  WIDTH  GPR write data
- whilo_o  out  1  HI/LO write enable
- hi_o  out  WIDTH  HI write data
- lo_o  out  WIDTH  LO write data
- stallreq_o  out  1  request to hold pc/if_id/id_ex

Behaviour:
- While rst==0, all outputs are forced to 0, the FSM goes to IDLE, and counter, accumulator and operand registers clear.
- Single-cycle ops (combinational from inputs):
  - AND, OR, XOR, NOR; SLL, SRL, SRA by reg1_i[4:0] applied to reg2_i.
  - MFHI/MFLO: wdata_o = hi_i / lo_i.
  - MOVZ: wreg_o = wreg_i & (reg2_i==0). MOVN: wreg_o = wreg_i & (reg2_i!=0). Data is reg1_i.
  - MTHI: whilo_o=1, hi_o=reg1_i, lo_o=lo_i. MTLO: whilo_o=1, lo_o=reg1_i, hi_o=hi_i.
  - Any other op: wdata_o=0, whilo_o=0.
- wd_o=wd_i always. wreg_o=wreg_i except for MOVZ/MOVN.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - MULT/MULTU on aluop_i (flush_i==0) latches the operands. MULT uses the magnitudes of both operands and records sign = reg1_i[31]^reg2_i[31]. MULTU uses the raw values.
  - acc=0, cnt=0, then go to MUL. stallreq_o=1 combinationally in this cycle.
- MUL:
  - Each cycle: if mplier[0], acc += mcand (2*WIDTH wide). Then mcand<<=1, mplier>>=1, cnt++.
  - Go to DONE after the step with cnt==31. stallreq_o=1 throughout.
- DONE:
  - stallreq_o=0. whilo_o=1, {hi_o,lo_o} = sign ? -acc : acc (two's complement over 64 bits). wreg_o=0.
  - Next state is IDLE unconditionally.
- Inputs are held stable by the pipeline while stallreq_o=1. The instruction advances on the DONE cycle edge.
- Back-to-back MULT: the next MULT starts from IDLE on the following cycle. There is no bubble beyond IDLE's start cycle.
- Latency with the option off: 34 cycles present, stallreq_o high for 33.
- whilo_o=0 in IDLE-start and MUL cycles. HI/LO are never written with partial products.
- flush_i=1 in any state: next state IDLE, and stallreq_o/whilo_o/wreg_o are 0 in that cycle. The partial result is discarded.
- Sign case: MULT with 0x80000000 operand uses magnitude 0x80000000 as unsigned. The result is exact, e.g. 0x80000000*0x80000000 = 0x40000000_00000000.

Optional Feature:
- Macro: EX_EARLY_TERM_EN.
- Defined: MUL exits to DONE after any step where the post-shift mplier==0, or cnt==31. The result is identical and latency = 2 + (index of highest set bit of multiplier magnitude + 1); multiplier 0 takes 1 MUL cycle.
- Undefined: fixed 32 MUL cycles.

Test Plan:
- OR reg1=0x0000F0F0, reg2=0x00000F0F, wreg_i=1, wd_i=5 -> same cycle: wdata_o=0x0000FFFF, wreg_o=1, wd_o=5, stallreq_o=0.
- MOVZ reg1=0x12345678, reg2=0 then reg2=1 -> wreg_o=1 with wdata_o=0x12345678, then wreg_o=0.
- MULT reg1=0xFFFFFFFE(-2), reg2=3 -> stallreq_o high for exactly 33 cycles. DONE cycle: whilo_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001. Back-to-back second MULTU 2*3 -> hi_o=0, lo_o=6, with no extra stall cycle between.
- MULT 7*9, flush_i pulsed at MUL cycle 10 -> stallreq_o=0 next cycle, whilo_o never asserted, FSM IDLE. Repeat with rst=0 mid-MUL -> all outputs 0.
- EX_EARLY_TERM_EN defined, MULTU 3*5 -> stallreq_o high for 4 cycles (1 start + 3 MUL), lo_o=15, hi_o=0.
